gaussian_stream_filter: RTL and testbench

GAUSSIAN_STREAM_FILTER -- requirements
Module: gaussian_stream_filter

---
 rtl/gaussian_stream_filter.sv | 193 +++++++++++++++++++
 tb/tb_gaussian_stream_filter.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gaussian_stream_filter.sv
// gaussian_stream_filter: 3x3 Gaussian smoothing of a raster-order pixel stream.
// Two line buffers feed a 3x3 window. Three register levels (window,
// accumulate, round/select) place each output two cycles after the pixel
// that completes its window. The input is never stalled.
module gaussian_stream_filter #(
  parameter int CH_W   = 4,
  parameter int CH_NUM = 3,
  parameter int IMG_W  = 320,
  parameter int IMG_H  = 240
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [1:0]             mode,
  input  logic                   in_valid,
  input  logic                   in_sof,
  input  logic [CH_W*CH_NUM-1:0] in_data,
  output logic                   out_valid,
  output logic                   out_sof,
  output logic [CH_W*CH_NUM-1:0] out_data
);

  localparam int PIX_W = CH_W * CH_NUM;
  localparam int ACC_W = CH_W + 4;
  localparam int XW    = $clog2(IMG_W);
  localparam int YW    = $clog2(IMG_H);
  localparam logic [XW-1:0] X_LAST = XW'(IMG_W - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(IMG_H - 1);

  // Window indexed [row][col]; row 2 is the incoming line, col 2 the newest column.
  typedef logic [2:0][2:0][PIX_W-1:0] win_t;

  function automatic logic [ACC_W-1:0] ext_ch(input logic [CH_W-1:0] v);
    return ACC_W'(v);
  endfunction

  // 1-2-1 / 2-4-2 / 1-2-1 weighted sum of one channel; max 16*(2^CH_W-1) fits ACC_W.
  function automatic logic [ACC_W-1:0] gauss_ch(input win_t w, input int c);
    logic [ACC_W-1:0] corners;
    logic [ACC_W-1:0] edges;
    logic [ACC_W-1:0] center;
    corners = ext_ch(w[0][0][c*CH_W +: CH_W]) + ext_ch(w[0][2][c*CH_W +: CH_W])
            + ext_ch(w[2][0][c*CH_W +: CH_W]) + ext_ch(w[2][2][c*CH_W +: CH_W]);
    edges   = ext_ch(w[0][1][c*CH_W +: CH_W]) + ext_ch(w[1][0][c*CH_W +: CH_W])
            + ext_ch(w[1][2][c*CH_W +: CH_W]) + ext_ch(w[2][1][c*CH_W +: CH_W]);
    center  = ext_ch(w[1][1][c*CH_W +: CH_W]);
    return corners + (edges << 1) + (center << 2);
  endfunction

  // Divide by 16, optionally rounding half up; the quotient always fits CH_W.
  function automatic logic [CH_W-1:0] round_ch(input logic [ACC_W-1:0] sum, input logic rnd);
    logic [ACC_W-1:0] biased;
    biased = rnd ? sum + ACC_W'(8) : sum;
    return biased[ACC_W-1:4];
  endfunction

  logic [XW-1:0]           x_q, x_d, x_cur;
  logic [YW-1:0]           y_q, y_d, y_cur;
  logic                    last_q, last_d;
  logic [1:0]              mode_q, mode_d;
  logic [PIX_W-1:0]        lb1_q [IMG_W];
  logic [PIX_W-1:0]        lb2_q [IMG_W];
  win_t                    win_p0_q, win_p0_d;
  logic                    vld_p0_q, vld_p0_d;
  logic                    sof_p0_q, sof_p0_d;
  logic                    bdr_p0_q, bdr_p0_d;
  logic [1:0]              mode_p0_q;
  logic [CH_NUM*ACC_W-1:0] sum_p1_q, sum_p1_d;
  logic [PIX_W-1:0]        ctr_p1_q;
  logic                    vld_p1_q, sof_p1_q, bdr_p1_q;
  logic [1:0]              mode_p1_q;
  logic                    out_valid_q, out_sof_q;
  logic [PIX_W-1:0]        out_data_q, out_data_d;

  // Stage p0: position tracking, mode latch and output-center qualification.
  always_comb begin
    x_cur    = in_sof ? '0 : x_q;
    y_cur    = in_sof ? '0 : y_q;
    x_d      = x_q;
    y_d      = y_q;
    last_d   = last_q;
    mode_d   = mode_q;
    vld_p0_d = 1'b0;
    sof_p0_d = 1'b0;
    bdr_p0_d = 1'b0;
    if (in_valid) begin
      if (x_cur == X_LAST) begin
        x_d = '0;
        y_d = (y_cur == Y_LAST) ? '0 : y_cur + 1'b1;
      end else begin
        x_d = x_cur + 1'b1;
        y_d = y_cur;
      end
      last_d = (x_cur == X_LAST) && (y_cur == Y_LAST);
      if (in_sof) mode_d = mode;
      if (x_cur != '0) begin
        // center (x-1, y-1); column 0 and row 0 are border
        vld_p0_d = (y_cur != '0);
        sof_p0_d = (x_cur == XW'(1)) && (y_cur == YW'(1));
        bdr_p0_d = (x_cur == XW'(1)) || (y_cur == YW'(1));
      end else begin
        // center (IMG_W-1, y-2); at y=0 this flushes row IMG_H-2 of a frame
        // that ran to completion, never a frame cut short by resync or reset
        vld_p0_d = (y_cur >= YW'(2)) || ((y_cur == '0) && last_q);
        bdr_p0_d = 1'b1;
      end
    end
  end

  // Stage p0: window shifts in a new column only on accepted pixels.
  always_comb begin
    win_p0_d = win_p0_q;
    if (in_valid) begin
      for (int r = 0; r < 3; r++) begin
        win_p0_d[r][0] = win_p0_q[r][1];
        win_p0_d[r][1] = win_p0_q[r][2];
      end
      win_p0_d[0][2] = lb2_q[x_cur];
      win_p0_d[1][2] = lb1_q[x_cur];
      win_p0_d[2][2] = in_data;
    end
  end

  // Stage p1: per-channel weighted sums.
  always_comb begin
    sum_p1_d = '0;
    for (int c = 0; c < CH_NUM; c++) begin
      sum_p1_d[c*ACC_W +: ACC_W] = gauss_ch(win_p0_q, c);
    end
  end

  // Stage p2: borders and modes 0/3 pass the raw center, modes 1/2 scale the sum.
  always_comb begin
    out_data_d = ctr_p1_q;
    if (!bdr_p1_q && (mode_p1_q == 2'd1 || mode_p1_q == 2'd2)) begin
      for (int c = 0; c < CH_NUM; c++) begin
        out_data_d[c*CH_W +: CH_W] = round_ch(sum_p1_q[c*ACC_W +: ACC_W], mode_p1_q == 2'd1);
      end
    end
  end

  // Line buffers: row y-1 in lb1, row y-2 in lb2, one column per accepted pixel.
  always_ff @(posedge clk) begin
    if (in_valid) begin
      lb2_q[x_cur] <= lb1_q[x_cur];
      lb1_q[x_cur] <= in_data;
    end
  end

  // Control state and output registers, cleared by reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      x_q         <= '0;
      y_q         <= '0;
      last_q      <= 1'b0;
      mode_q      <= 2'd1;
      vld_p0_q    <= 1'b0;
      sof_p0_q    <= 1'b0;
      vld_p1_q    <= 1'b0;
      sof_p1_q    <= 1'b0;
      out_valid_q <= 1'b0;
      out_sof_q   <= 1'b0;
      out_data_q  <= '0;
    end else begin
      x_q         <= x_d;
      y_q         <= y_d;
      last_q      <= last_d;
      mode_q      <= mode_d;
      vld_p0_q    <= vld_p0_d;
      sof_p0_q    <= sof_p0_d;
      vld_p1_q    <= vld_p0_q;
      sof_p1_q    <= sof_p0_q;
      out_valid_q <= vld_p1_q;
      out_sof_q   <= sof_p1_q;
      out_data_q  <= out_data_d;
    end
  end

  // Datapath registers follow their valids and need no reset.
  always_ff @(posedge clk) begin
    win_p0_q  <= win_p0_d;
    bdr_p0_q  <= bdr_p0_d;
    mode_p0_q <= mode_d;
    sum_p1_q  <= sum_p1_d;
    ctr_p1_q  <= win_p0_q[1][1];
    bdr_p1_q  <= bdr_p0_q;
    mode_p1_q <= mode_p0_q;
  end

  assign out_valid = out_valid_q;
  assign out_sof   = out_sof_q;
  assign out_data  = out_data_q;

endmodule

// File: tb/tb_gaussian_stream_filter.sv
// Directed bench for gaussian_stream_filter on a 4x4 RGB444 image.
`timescale 1ns/1ps
module tb_gaussian_stream_filter;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  mode;
  logic        in_valid;
  logic        in_sof;
  logic [11:0] in_data;
  logic        out_valid;
  logic        out_sof;
  logic [11:0] out_data;

  int tests_run    = 0;
  int tests_failed = 0;
  int cyc          = 0;

  int          in_q[$];
  int          oc_q[$];
  logic [11:0] od_q[$];
  logic        os_q[$];

  // Expected outputs for the 0xF00 impulse at (1,1), centers in raster order.
  logic [11:0] exp_rnd [12] = '{12'h000, 12'h000, 12'h000, 12'h000,
                                12'h000, 12'h400, 12'h200, 12'h000,
                                12'h000, 12'h200, 12'h100, 12'h000};
  logic [11:0] exp_trn [12] = '{12'h000, 12'h000, 12'h000, 12'h000,
                                12'h000, 12'h300, 12'h100, 12'h000,
                                12'h000, 12'h100, 12'h000, 12'h000};

  always #5 clk = ~clk;

  gaussian_stream_filter #(
    .CH_W(4), .CH_NUM(3), .IMG_W(4), .IMG_H(4)
  ) dut (
    .clk(clk), .reset(reset), .mode(mode),
    .in_valid(in_valid), .in_sof(in_sof), .in_data(in_data),
    .out_valid(out_valid), .out_sof(out_sof), .out_data(out_data)
  );

  // Log accepted-input edges and, just after each edge, any output produced.
  always @(posedge clk) begin
    cyc = cyc + 1;
    if (in_valid === 1'b1 && reset === 1'b0) in_q.push_back(cyc);
    #1;
    if (out_valid === 1'b1) begin
      od_q.push_back(out_data);
      os_q.push_back(out_sof);
      oc_q.push_back(cyc);
    end
  end

  task automatic clear_log();
    in_q.delete();
    oc_q.delete();
    od_q.delete();
    os_q.delete();
  endtask

  task automatic drive(input logic v, input logic s, input logic [1:0] m, input logic [11:0] d);
    @(negedge clk);
    in_valid = v;
    in_sof   = s;
    mode     = m;
    in_data  = d;
  endtask

  // One frame with in_sof on pixel 0, then the next frame's sof pixel to flush the last
  // center. The wanted mode is presented only on sof pixels; other pixels carry another mode.
  task automatic send_frame(input logic [11:0] pix [16], input logic [1:0] m, input int gap);
    logic [1:0] other;
    int n;
    other = (m == 2'd1) ? 2'd2 : 2'd1;
    for (int i = 0; i < 17; i++) begin
      if (gap > 0) begin
        n = int'($urandom_range(gap, 0));
        repeat (n) drive(1'b0, 1'b0, other, 12'hABC);
      end
      if (i == 16) drive(1'b1, 1'b1, m, 12'h000);
      else         drive(1'b1, i == 0, (i == 0) ? m : other, pix[i]);
    end
    repeat (5) drive(1'b0, 1'b0, other, 12'h000);
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b1; in_sof = 1'b0; mode = 2'd0; in_data = 12'hFFF;
    repeat (2) @(posedge clk);
    #1;
    tests_run++;
    if (out_valid !== 1'b0) begin
      tests_failed++; $display("FAIL reset_out_valid: got %b, expected 0", out_valid);
    end
    tests_run++;
    if (out_sof !== 1'b0) begin
      tests_failed++; $display("FAIL reset_out_sof: got %b, expected 0", out_sof);
    end
    tests_run++;
    if (out_data !== 12'h000) begin
      tests_failed++; $display("FAIL reset_out_data: got %h, expected 000", out_data);
    end
    @(negedge clk);
    reset = 1'b0; in_valid = 1'b0;
  endtask

  task automatic test_flat();
    logic [11:0] pix [16];
    for (int i = 0; i < 16; i++) pix[i] = 12'hFFF;
    clear_log();
    send_frame(pix, 2'd1, 0);
    tests_run++;
    if (od_q.size() != 12 || in_q.size() != 17) begin
      tests_failed++;
      $display("FAIL flat_count: got %0d outputs for %0d inputs, expected 12 for 17", od_q.size(), in_q.size());
    end else begin
      for (int k = 0; k < 12; k++) begin
        tests_run++;
        if (od_q[k] !== 12'hFFF || os_q[k] !== (k == 0)) begin
          tests_failed++;
          $display("FAIL flat_out[%0d]: got data %h sof %b, expected FFF sof %b", k, od_q[k], os_q[k], k == 0);
        end
        tests_run++;
        if (oc_q[k] - in_q[k+5] !== 2) begin
          tests_failed++;
          $display("FAIL flat_latency[%0d]: got %0d cycles, expected 2", k, oc_q[k] - in_q[k+5]);
        end
      end
    end
  endtask

  task automatic test_impulse(input logic [1:0] m);
    logic [11:0] pix [16];
    logic [11:0] exp_v;
    for (int i = 0; i < 16; i++) pix[i] = (i == 5) ? 12'hF00 : 12'h000;
    clear_log();
    send_frame(pix, m, 0);
    tests_run++;
    if (od_q.size() != 12) begin
      tests_failed++;
      $display("FAIL impulse_m%0d_count: got %0d outputs, expected 12", m, od_q.size());
    end else begin
      for (int k = 0; k < 12; k++) begin
        exp_v = (m == 2'd1) ? exp_rnd[k] : exp_trn[k];
        tests_run++;
        if (od_q[k] !== exp_v || os_q[k] !== (k == 0)) begin
          tests_failed++;
          $display("FAIL impulse_m%0d_out[%0d]: got data %h sof %b, expected %h sof %b",
                   m, k, od_q[k], os_q[k], exp_v, k == 0);
        end
      end
    end
  endtask

  task automatic test_bypass();
    logic [11:0] pix [16];
    logic [11:0] exp_v;
    for (int i = 0; i < 16; i++) pix[i] = 12'(12'h100 + i * 13);
    clear_log();
    send_frame(pix, 2'd0, 0);
    tests_run++;
    if (od_q.size() != 12 || in_q.size() != 17) begin
      tests_failed++;
      $display("FAIL bypass_count: got %0d outputs for %0d inputs, expected 12 for 17", od_q.size(), in_q.size());
    end else begin
      for (int k = 0; k < 12; k++) begin
        exp_v = 12'(12'h100 + k * 13);
        tests_run++;
        if (od_q[k] !== exp_v || oc_q[k] - in_q[k+5] !== 2) begin
          tests_failed++;
          $display("FAIL bypass_out[%0d]: got data %h latency %0d, expected %h latency 2",
                   k, od_q[k], oc_q[k] - in_q[k+5], exp_v);
        end
      end
    end
  endtask

  task automatic test_gaps();
    logic [11:0] pix [16];
    for (int i = 0; i < 16; i++) pix[i] = (i == 5) ? 12'hF00 : 12'h000;
    clear_log();
    send_frame(pix, 2'd1, 3);
    tests_run++;
    if (od_q.size() != 12 || in_q.size() != 17) begin
      tests_failed++;
      $display("FAIL gaps_count: got %0d outputs for %0d inputs, expected 12 for 17", od_q.size(), in_q.size());
    end else begin
      for (int k = 0; k < 12; k++) begin
        tests_run++;
        if (od_q[k] !== exp_rnd[k] || os_q[k] !== (k == 0)) begin
          tests_failed++;
          $display("FAIL gaps_out[%0d]: got data %h sof %b, expected %h sof %b",
                   k, od_q[k], os_q[k], exp_rnd[k], k == 0);
        end
        tests_run++;
        if (oc_q[k] - in_q[k+5] !== 2) begin
          tests_failed++;
          $display("FAIL gaps_latency[%0d]: got %0d cycles, expected 2", k, oc_q[k] - in_q[k+5]);
        end
      end
    end
  endtask

  task automatic test_resync();
    logic [11:0] exp_v;
    logic        exp_s;
    int          src;
    clear_log();
    // old frame in mode 1; mode input moves to 2 partway through
    for (int i = 0; i < 7; i++) drive(1'b1, i == 0, (i >= 3) ? 2'd2 : 2'd1, 12'(12'h0A0 + i));
    // in_sof at input pixel 7 starts a new frame, latching mode 2
    for (int i = 0; i < 16; i++) drive(1'b1, i == 0, (i == 0) ? 2'd2 : 2'd1, (i == 5) ? 12'hF00 : 12'h000);
    drive(1'b1, 1'b1, 2'd2, 12'h000);
    repeat (5) drive(1'b0, 1'b0, 2'd1, 12'h000);
    tests_run++;
    if (od_q.size() != 14 || in_q.size() != 24) begin
      tests_failed++;
      $display("FAIL resync_count: got %0d outputs for %0d inputs, expected 14 for 24", od_q.size(), in_q.size());
    end else begin
      for (int k = 0; k < 14; k++) begin
        if (k < 2) begin
          exp_v = 12'(12'h0A0 + k); exp_s = (k == 0); src = k + 5;
        end else begin
          exp_v = exp_trn[k-2]; exp_s = (k == 2); src = k + 10;
        end
        tests_run++;
        if (od_q[k] !== exp_v || os_q[k] !== exp_s || oc_q[k] - in_q[src] !== 2) begin
          tests_failed++;
          $display("FAIL resync_out[%0d]: got data %h sof %b latency %0d, expected %h sof %b latency 2",
                   k, od_q[k], os_q[k], oc_q[k] - in_q[src], exp_v, exp_s);
        end
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    clear_log();
    for (int i = 0; i < 7; i++) drive(1'b1, i == 0, 2'd1, 12'h777);
    @(negedge clk);
    in_valid = 1'b0; reset = 1'b1;
    @(posedge clk);
    #1;
    tests_run++;
    if (out_valid !== 1'b0) begin
      tests_failed++; $display("FAIL midreset_out_valid: got %b, expected 0", out_valid);
    end
    @(negedge clk);
    reset = 1'b0;
    repeat (4) @(negedge clk);
    tests_run++;
    if (od_q.size() != 0) begin
      tests_failed++; $display("FAIL midreset_dropped: got %0d outputs, expected 0", od_q.size());
    end
  endtask

  task automatic test_no_sof_after_reset();
    clear_log();
    for (int i = 0; i < 16; i++) drive(1'b1, 1'b0, 2'd2, 12'h5A3);
    repeat (5) drive(1'b0, 1'b0, 2'd2, 12'h000);
    tests_run++;
    if (od_q.size() != 11 || in_q.size() != 16) begin
      tests_failed++;
      $display("FAIL nosof_count: got %0d outputs for %0d inputs, expected 11 for 16", od_q.size(), in_q.size());
    end else begin
      for (int k = 0; k < 11; k++) begin
        tests_run++;
        if (od_q[k] !== 12'h5A3 || os_q[k] !== (k == 0) || oc_q[k] - in_q[k+5] !== 2) begin
          tests_failed++;
          $display("FAIL nosof_out[%0d]: got data %h sof %b latency %0d, expected 5A3 sof %b latency 2",
                   k, od_q[k], os_q[k], oc_q[k] - in_q[k+5], k == 0);
        end
      end
    end
  endtask

  initial begin
    void'($urandom(32'd7));
    test_reset();
    test_flat();
    test_impulse(2'd1);
    test_impulse(2'd2);
    test_bypass();
    test_gaps();
    test_resync();
    test_reset_mid_frame();
    test_no_sof_after_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded 200000 ns");
    $fatal(1, "timeout");
  end

endmodule
